serial_chunk_adder: RTL and testbench
=====================================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits, at least 2.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port in_valid: input, 1 bit, operands offered.
REQ-007 Port in_ready: output, 1 bit, block can accept operands.
REQ-008 Port a: input, WIDTH bits, operand A.
REQ-009 Port b: input, WIDTH bits, operand B.
REQ-010 Port cin: input, 1 bit, carry-in.
REQ-011 Port out_valid: output, 1 bit, result available.
REQ-012 Port out_ready: input, 1 bit, consumer takes result.
REQ-013 Port sum: output, WIDTH bits, (a+b+cin) mod 2^WIDTH.
REQ-014 Port cout: output, 1 bit, unsigned carry-out.
REQ-015 Port ovf: output, 1 bit, two's-complement overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1 and out_valid=0; when in_valid=1 at a clock edge, the block SHALL latch a, b and cin, clear the chunk counter, and enter RUN.
REQ-018 RUN: in_ready=0; each cycle it SHALL add chunk[count] of A and B plus the carry register, write that chunk of sum, update the carry register, and increment count.
REQ-019 RUN SHALL last exactly NCHUNK cycles, then enter DONE; out_valid SHALL rise NCHUNK clock edges after the accepting edge.
REQ-020 DONE: out_valid=1 and in_ready=0; sum, cout and ovf SHALL be held stable; on out_ready=1 at a clock edge, the block SHALL return to IDLE.
REQ-021 cout SHALL equal the carry out of bit WIDTH-1; ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE; no operand is lost or duplicated.
REQ-023 Chunk 0 SHALL be the least-significant chunk; the initial carry SHALL be the latched cin.
REQ-024 sum, cout and ovf SHALL change only in RUN and SHALL otherwise retain the last result.
REQ-025 CHUNK=WIDTH SHALL give one RUN cycle (latency 1); CHUNK=1 SHALL give WIDTH RUN cycles.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-RUN, and discard the operation in flight.
REQ-027 Reset values SHALL be: out_valid=0, sum=0, cout=0, ovf=0, count=0, carry register=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-028 Handshakes presented during a reset cycle SHALL be ignored.

Structure
REQ-029 A shared package adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a function computing NCHUNK.
REQ-030 The parameter legality check (WIDTH % CHUNK == 0) SHALL be an elaboration-time assertion in the module.
REQ-031 One sub-module, chunk_adder, SHALL implement a combinational CHUNK-bit ripple adder with ports a, b, cin, s, cout and c_msb_in (carry into the top bit).
REQ-032 The top module SHALL contain only the FSM, counter, operand/carry registers, and one chunk_adder instance.

Verification (WIDTH=8, CHUNK=2, NCHUNK=4 unless stated)
REQ-033 a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0; out_valid rises exactly 4 edges after acceptance.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-035 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid stays 1, sum stays stable, in_ready=0, and the new operands are not taken.
REQ-037 Assert rst during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; then a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-038 CHUNK=8: a=0x80, b=0x80, cin=0 -> out_valid rises 1 edge after acceptance, with sum=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial chunk adder.
//   state_t      : controller states (IDLE, RUN, DONE)
//   calc_nchunk  : number of CHUNK-bit slices in a WIDTH-bit operand
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple-carry adder slice.
// Ports:
//   a, b      : W-bit addends
//   cin       : carry into bit 0
//   s         : W-bit sum
//   cout      : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (used for signed overflow on the top slice)
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = w_c[W];
  assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Serial adder: adds two WIDTH-bit operands CHUNK bits per clock, least
// significant chunk first, with a valid/ready handshake on both sides.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin latched on accept)
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : (a+b+cin) mod 2^WIDTH, unsigned carry, signed overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one chunk added per cycle, NCHUNK cycles
// DONE  | result held, out_valid=1 until out_ready
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK-1:0]   w_s;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_last;

  assign w_last = (r_cnt == LAST);

  // Select the operand slice addressed by the chunk counter.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a        (w_a_chunk),
    .b        (w_b_chunk),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CNT_W'(i)) r_sum[i*CHUNK +: CHUNK] <= w_s;
          end
          r_carry <= w_cout;
          // Flags come only from the top slice, so they are taken on the last chunk.
          if (w_last) begin
            r_cnt  <= '0;
            r_cout <= w_cout;
            r_ovf  <= w_cmsb ^ w_cout;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // index 0: WIDTH=8 CHUNK=2 ; index 1: WIDTH=8 CHUNK=8
  logic [1:0]      rst_v;
  logic [1:0]      in_valid_v;
  logic [1:0]      out_ready_v;
  logic [1:0][7:0] a_v;
  logic [1:0][7:0] b_v;
  logic [1:0]      cin_v;
  wire  [1:0]      in_ready_v;
  wire  [1:0]      out_valid_v;
  wire  [1:0][7:0] sum_v;
  wire  [1:0]      cout_v;
  wire  [1:0]      ovf_v;

  exp_t sb[2][$];
  logic [1:0] prev_ov = 2'b00;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands to DUT d; push the hand-computed result once accepted.
  task automatic send(input int d, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    int t;
    exp_t e;
    t = 0;
    a_v[d] = ta; b_v[d] = tb_; cin_v[d] = tc; in_valid_v[d] = 1'b1;
    while (!in_ready_v[d] && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready_v[d]) begin
      check("send_timeout_in_ready", 32'(in_ready_v[d]), 32'd1);
      in_valid_v[d] = 1'b0;
      return;
    end
    tick();
    in_valid_v[d] = 1'b0;
    e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc;
    sb[d].push_back(e);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (sb[d].size() != 0 && t < 200) begin
      tick();
      t++;
    end
    if (sb[d].size() != 0) begin
      check("drain_timeout", 32'(sb[d].size()), 32'd0);
      sb[d].delete();
    end
  endtask

  // Monitor: latency on out_valid rise, data compare on each consumed result.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        prev_ov[d] = 1'b0;
      end else begin
        if (out_valid_v[d] && !prev_ov[d]) begin
          if (sb[d].size() == 0) check($sformatf("unexpected_result_d%0d", d), 32'd1, 32'd0);
          else check($sformatf("latency_d%0d", d), 32'(cyc - sb[d][0].acc), (d == 0) ? 32'd4 : 32'd1);
        end
        if (out_valid_v[d] && out_ready_v[d] && sb[d].size() != 0) begin
          exp_t e;
          e = sb[d].pop_front();
          check($sformatf("sum_d%0d", d),  32'(sum_v[d]),  32'(e.sum));
          check($sformatf("cout_d%0d", d), 32'(cout_v[d]), 32'(e.cout));
          check($sformatf("ovf_d%0d", d),  32'(ovf_v[d]),  32'(e.ovf));
        end
        prev_ov[d] = out_valid_v[d];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_v = 2'b11; out_ready_v = 2'b11; cin_v = 2'b11;
    // Handshakes during reset must be ignored.
    in_valid_v = 2'b11; a_v[0] = 8'hFF; b_v[0] = 8'hFF; a_v[1] = 8'hFF; b_v[1] = 8'hFF;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid_d%0d", d), 32'(out_valid_v[d]), 32'd0);
      check($sformatf("rst_sum_d%0d", d),       32'(sum_v[d]),       32'd0);
      check($sformatf("rst_cout_d%0d", d),      32'(cout_v[d]),      32'd0);
      check($sformatf("rst_ovf_d%0d", d),       32'(ovf_v[d]),       32'd0);
    end
    in_valid_v = 2'b00; rst_v = 2'b00;
    tick();
    check("post_rst_in_ready_d0", 32'(in_ready_v[0]), 32'd1);
    check("post_rst_in_ready_d1", 32'(in_ready_v[1]), 32'd1);
    repeat (8) tick();
    check("rst_handshake_ignored_d0", 32'(out_valid_v[0]), 32'd0);

    // Directed vectors, CHUNK=2
    send(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    send(0, 8'hC3, 8'h5A, 1'b0, 8'h1D, 1'b1, 1'b0);
    send(0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    send(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drain(0);

    // Hold in DONE with out_ready low while new operands are offered.
    out_ready_v[0] = 1'b0;
    send(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    t = 0;
    while (!out_valid_v[0] && t < 50) begin
      tick();
      t++;
    end
    check("hold_reached_done", 32'(out_valid_v[0]), 32'd1);
    a_v[0] = 8'hFF; b_v[0] = 8'hFF; cin_v[0] = 1'b1; in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid_v[0]), 32'd1);
      check("hold_in_ready",  32'(in_ready_v[0]),  32'd0);
      check("hold_sum",       32'(sum_v[0]),       32'h47);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    drain(0);
    repeat (8) tick();
    check("hold_no_extra_accept", 32'(in_ready_v[0]), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    a_v[0] = 8'hC3; b_v[0] = 8'h5A; cin_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    check("midrun_rst_in_ready",  32'(in_ready_v[0]),  32'd1);
    check("midrun_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrun_rst_sum",       32'(sum_v[0]),       32'd0);
    send(0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    drain(0);

    // CHUNK=8: single RUN cycle
    send(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    send(1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    send(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drain(1);

    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
